// File: rtl/zorro2_pkg.sv
// rtl/zorro2_pkg.sv - shared AutoConfig offsets, state encoding and er_Type constants
package zorro2_pkg;

  // AutoConfig register offsets expressed as A[6:1]
  localparam logic [5:0] OFF_TYPE   = 6'h00;
  localparam logic [5:0] OFF_BASE   = 6'h24;
  localparam logic [5:0] OFF_SHUTUP = 6'h26;

  // A[23:16] value of the Zorro II AutoConfig window
  localparam logic [7:0] CFG_SPACE  = 8'hE8;

  // er_Type: Zorro II, memory-pool link; size field 000=8MB, 111=4MB
  localparam logic [7:0] ER_TYPE_8M = 8'hE0;
  localparam logic [7:0] ER_TYPE_4M = 8'hE7;

  // er_Flags: board may be shut up
  localparam logic [7:0] ER_FLAGS   = 8'h80;

  typedef enum logic [1:0] {
    ST_UNCONF = 2'd0,
    ST_CONFIG = 2'd1,
    ST_SHUTUP = 2'd2
  } ac_state_e;

  // Each AutoConfig byte occupies two nibble slots: high nibble first
  function automatic logic [3:0] nib_sel(input logic [7:0] b, input logic lo);
    return lo ? b[3:0] : b[7:4];
  endfunction

endpackage

// File: rtl/autoconfig_rom.sv
// rtl/autoconfig_rom.sv - combinational AutoConfig ROM, nibble per A[6:1] slot
module autoconfig_rom
  import zorro2_pkg::*;
#(
  parameter logic [15:0] MANUF_ID   = 16'h07DB,
  parameter logic [7:0]  PRODUCT_ID = 8'h01,
  parameter logic [31:0] SERIAL     = 32'h0000_0001
) (
  input  logic [5:0] off_i,
  input  logic       size_8m_i,
  output logic [3:0] nibble_o
);

  logic [7:0] raw_byte;
  logic [7:0] bus_byte;
  logic       invert;
  logic       defined;

  // Select the logical byte for this slot pair; everything but er_Type and the
  // control register is presented inverted on the bus
  always_comb begin
    raw_byte = 8'h00;
    invert   = 1'b1;
    defined  = 1'b1;
    case (off_i[5:1])
      OFF_TYPE[5:1]: begin
        raw_byte = size_8m_i ? ER_TYPE_8M : ER_TYPE_4M;
        invert   = 1'b0;
      end
      5'h01: raw_byte = PRODUCT_ID;
      5'h02: raw_byte = ER_FLAGS;
      5'h04: raw_byte = MANUF_ID[15:8];
      5'h05: raw_byte = MANUF_ID[7:0];
      5'h06: raw_byte = SERIAL[31:24];
      5'h07: raw_byte = SERIAL[23:16];
      5'h08: raw_byte = SERIAL[15:8];
      5'h09: raw_byte = SERIAL[7:0];
      5'h0A: raw_byte = 8'h00;
      5'h0B: raw_byte = 8'h00;
      5'h10: begin
        raw_byte = 8'h00;
        invert   = 1'b0;
      end
      default: defined = 1'b0;
    endcase
    bus_byte = invert ? ~raw_byte : raw_byte;
    nibble_o = defined ? nib_sel(bus_byte, off_i[0]) : 4'hF;
  end

endmodule

// File: rtl/zorro2_autoconfig.sv
// rtl/zorro2_autoconfig.sv - Zorro II AutoConfig responder for the fast-RAM board
module zorro2_autoconfig
  import zorro2_pkg::*;
#(
  parameter logic [15:0] MANUF_ID   = 16'h07DB,
  parameter logic [7:0]  PRODUCT_ID = 8'h01,
  parameter logic [31:0] SERIAL     = 32'h0000_0001
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [23:1] A,
  input  logic        AS_n,
  input  logic        RW_n,
  input  logic        UDS_n,
  input  logic [3:0]  D_IN,
  output logic [3:0]  D_OUT,
  output logic        D_OE,
  input  logic        CFGIN_n,
  output logic        CFGOUT_n,
  input  logic        JP2,
  output logic [2:0]  BASE_RAM,
  output logic        RAM_CONFIGURED_n,
  output logic        CFG_ACCESS
);

  ac_state_e  state_q, state_d;
  logic       armed_q, armed_d;
  logic       wait_idle_q, wait_idle_d;
  logic       size_8m_q;
  logic [3:0] d_out_q, d_out_d;
  logic       d_oe_q, d_oe_d;
  logic       cfgout_n_q, cfgout_n_d;
  logic [2:0] base_q, base_d;
  logic       ram_cfg_n_q, ram_cfg_n_d;
  logic       cfg_access_q;

  logic       in_space;
  logic       rd_hit;
  logic       commit;
  logic [3:0] rom_nibble;

  // Address bits outside the window decode and D[12] carry no meaning here
  logic unused_bits;
  assign unused_bits = ^{A[15:7], D_IN[0]};

  assign in_space = (A[23:16] == CFG_SPACE) && !AS_n && !CFGIN_n && (state_q == ST_UNCONF);
  // wait_idle_q blocks a bus cycle that straddled RESET from being answered
  assign rd_hit   = in_space && RW_n && !wait_idle_q;
  assign commit   = in_space && !RW_n && !UDS_n && armed_q && !wait_idle_q;

  autoconfig_rom #(
    .MANUF_ID   (MANUF_ID),
    .PRODUCT_ID (PRODUCT_ID),
    .SERIAL     (SERIAL)
  ) u_rom (
    .off_i     (A[6:1]),
    .size_8m_i (size_8m_q),
    .nibble_o  (rom_nibble)
  );

  // Next state: bus cycle bookkeeping, read data launch and base-address commit
  always_comb begin
    state_d     = state_q;
    armed_d     = armed_q;
    wait_idle_d = wait_idle_q;
    d_out_d     = d_out_q;
    d_oe_d      = d_oe_q;
    cfgout_n_d  = cfgout_n_q;
    base_d      = base_q;
    ram_cfg_n_d = ram_cfg_n_q;

    if (AS_n) begin
      d_oe_d      = 1'b0;
      armed_d     = 1'b1;
      wait_idle_d = 1'b0;
    end

    if (rd_hit) begin
      d_oe_d  = 1'b1;
      d_out_d = rom_nibble;
    end

    if (commit) begin
      armed_d = 1'b0;
      case (A[6:1])
        OFF_BASE: begin
          state_d     = ST_CONFIG;
          base_d      = D_IN[3:1];
          ram_cfg_n_d = 1'b0;
          cfgout_n_d  = 1'b0;
        end
        OFF_SHUTUP: begin
          state_d    = ST_SHUTUP;
          cfgout_n_d = 1'b0;
        end
        default: ;
      endcase
    end

    // Configured or shut-up boards no longer drive the data bus
    if (state_q != ST_UNCONF) begin
      d_oe_d = 1'b0;
    end
  end

  // State and output registers; JP2 is only sampled while RESET is asserted
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= ST_UNCONF;
      armed_q      <= 1'b1;
      wait_idle_q  <= !AS_n;
      size_8m_q    <= JP2;
      d_out_q      <= 4'h0;
      d_oe_q       <= 1'b0;
      cfgout_n_q   <= 1'b1;
      base_q       <= 3'b000;
      ram_cfg_n_q  <= 1'b1;
      cfg_access_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      armed_q      <= armed_d;
      wait_idle_q  <= wait_idle_d;
      d_out_q      <= d_out_d;
      d_oe_q       <= d_oe_d;
      cfgout_n_q   <= cfgout_n_d;
      base_q       <= base_d;
      ram_cfg_n_q  <= ram_cfg_n_d;
      cfg_access_q <= in_space;
    end
  end

  assign D_OUT            = d_out_q;
  assign D_OE             = d_oe_q;
  assign CFGOUT_n         = cfgout_n_q;
  assign BASE_RAM         = base_q;
  assign RAM_CONFIGURED_n = ram_cfg_n_q;
  assign CFG_ACCESS       = cfg_access_q;

endmodule

// File: tb/tb_zorro2_autoconfig.sv
// tb/tb_zorro2_autoconfig.sv - scoreboard bench for zorro2_autoconfig
module tb_zorro2_autoconfig;

  logic        CLK = 1'b0;
  logic        RESET, AS_n, RW_n, UDS_n, CFGIN_n, JP2;
  logic [23:1] A;
  logic [3:0]  D_IN;
  logic [3:0]  D_OUT;
  logic        D_OE, CFGOUT_n, RAM_CONFIGURED_n, CFG_ACCESS;
  logic [2:0]  BASE_RAM;

  zorro2_autoconfig dut (
    .CLK(CLK), .RESET(RESET), .A(A), .AS_n(AS_n), .RW_n(RW_n), .UDS_n(UDS_n),
    .D_IN(D_IN), .D_OUT(D_OUT), .D_OE(D_OE), .CFGIN_n(CFGIN_n), .CFGOUT_n(CFGOUT_n),
    .JP2(JP2), .BASE_RAM(BASE_RAM), .RAM_CONFIGURED_n(RAM_CONFIGURED_n),
    .CFG_ACCESS(CFG_ACCESS)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit       oe;
    bit [3:0] data;
    bit       acc;
    bit [2:0] base;
    bit       ram_n;
    bit       cfgout_n;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Board model: 0 = unconfigured, 1 = configured, 2 = shut up
  int       m_state = 0;
  bit       m_8m    = 1'b1;
  bit [2:0] m_base  = 3'b000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
    end
  endtask

  // Config ROM as logical bytes; byte address r covers bus slots r and r+2
  function automatic bit [3:0] ref_nibble(input int idx, input bit big);
    int       ba;
    int       r;
    bit       lo;
    bit       inv;
    bit       def;
    bit [7:0] v;
    bit [31:0] ser;
    ba  = idx * 2;
    r   = ba & 'h7C;
    lo  = (ba & 2) != 0;
    inv = 1'b1;
    def = 1'b1;
    v   = 8'h00;
    ser = 32'h0000_0001;
    if (r == 'h00) begin
      v = big ? 8'hE0 : 8'hE7;
      inv = 1'b0;
    end else if (r == 'h04) v = 8'h01;
    else if (r == 'h08) v = 8'h80;
    else if (r == 'h10) v = 8'h07;
    else if (r == 'h14) v = 8'hDB;
    else if (r >= 'h18 && r <= 'h24) v = 8'(ser >> (8 * (3 - (r - 'h18) / 4)));
    else if (r == 'h28 || r == 'h2C) v = 8'h00;
    else if (r == 'h40) begin
      v = 8'h00;
      inv = 1'b0;
    end else def = 1'b0;
    if (!def) return 4'hF;
    if (inv) v = ~v;
    return lo ? v[3:0] : v[7:4];
  endfunction

  task automatic push_exp(input bit oe, input bit [3:0] d, input bit acc);
    exp_t e;
    e.oe       = oe;
    e.data     = d;
    e.acc      = acc;
    e.base     = m_base;
    e.ram_n    = (m_state == 1) ? 1'b0 : 1'b1;
    e.cfgout_n = (m_state == 0) ? 1'b1 : 1'b0;
    sbq.push_back(e);
  endtask

  task automatic do_reset(input bit jp);
    @(posedge CLK); #2;
    RESET = 1'b1;
    JP2   = jp;
    @(posedge CLK); #2;
    RESET   = 1'b0;
    JP2     = 1'($urandom);
    m_state = 0;
    m_base  = 3'b000;
    m_8m    = jp;
    @(negedge CLK);
    chk("rst_d_oe", D_OE, 0);
    chk("rst_d_out", D_OUT, 0);
    chk("rst_cfgout_n", CFGOUT_n, 1);
    chk("rst_base", BASE_RAM, 0);
    chk("rst_ram_cfg_n", RAM_CONFIGURED_n, 1);
    chk("rst_cfg_access", CFG_ACCESS, 0);
  endtask

  // One complete bus cycle plus the model's view of what it should do
  task automatic bus(input bit [7:0] hi, input int idx, input bit rw, input bit [3:0] d,
                     input bit cfgin, input int hold);
    bit hit;
    hit = (hi == 8'hE8) && !cfgin && (m_state == 0);
    if (rw) begin
      push_exp(hit, hit ? ref_nibble(idx, m_8m) : 4'h0, hit);
    end else begin
      if (hit && idx == 'h24) begin
        m_state = 1;
        m_base  = d[3:1];
      end else if (hit && idx == 'h26) begin
        m_state = 2;
      end
      push_exp(1'b0, 4'h0, hit);
    end
    @(posedge CLK); #2;
    A       = {hi, 9'($urandom), 6'(idx)};
    RW_n    = rw;
    D_IN    = d;
    CFGIN_n = cfgin;
    UDS_n   = 1'b0;
    AS_n    = 1'b0;
    repeat (hold) @(posedge CLK);
    #2;
    AS_n  = 1'b1;
    UDS_n = 1'b1;
  endtask

  task automatic rand_read();
    int idx;
    bit [7:0] hi;
    idx = $urandom_range(0, 63);
    if (idx == 32 || idx == 33) idx = 48;
    hi  = ($urandom_range(0, 9) < 8) ? 8'hE8 : 8'($urandom);
    bus(hi, idx, 1'b1, 4'($urandom), ($urandom_range(0, 9) == 0), $urandom_range(2, 4));
  endtask

  task automatic rand_write(input bit allow_commit);
    int idx;
    int sel;
    idx = $urandom_range(0, 63);
    if (idx == 'h24 || idx == 'h26) idx = 'h25;
    sel = $urandom_range(0, 9);
    if (allow_commit && sel == 0) idx = 'h24;
    if (allow_commit && sel == 1) idx = 'h26;
    bus(($urandom_range(0, 9) < 8) ? 8'hE8 : 8'h00, idx, 1'b0, 4'($urandom),
        ($urandom_range(0, 9) == 0), $urandom_range(2, 4));
  endtask

  // Monitor: one scoreboard entry per AS_n-low period seen on the pins
  initial begin : monitor
    int   cnt;
    bit   have;
    exp_t cur;
    cnt  = 0;
    have = 1'b0;
    forever begin
      @(negedge CLK);
      if (!AS_n) begin
        cnt++;
        if (cnt == 1) begin
          if (sbq.size() == 0) begin
            have = 1'b0;
            chk("sb_underflow", 1, 0);
          end else begin
            cur  = sbq.pop_front();
            have = 1'b1;
          end
          chk("oe_idle_at_start", D_OE, 0);
        end else if (cnt == 2 && have) begin
          chk("oe_latency", D_OE, cur.oe);
          chk("cfg_access", CFG_ACCESS, cur.acc);
          if (cur.oe) chk("read_data", D_OUT, cur.data);
        end
      end else if (cnt > 0) begin
        if (have) begin
          chk("oe_hold", D_OE, cur.oe);
          chk("base_ram", BASE_RAM, cur.base);
          chk("ram_cfg_n", RAM_CONFIGURED_n, cur.ram_n);
          chk("cfgout_n", CFGOUT_n, cur.cfgout_n);
        end
        cnt  = 0;
        have = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : stim
    RESET = 1'b0; AS_n = 1'b1; RW_n = 1'b1; UDS_n = 1'b1;
    CFGIN_n = 1'b0; JP2 = 1'b1; A = '0; D_IN = 4'h0;

    // 8MB mode: er_Type and random ROM reads
    do_reset(1'b1);
    bus(8'hE8, 0, 1'b1, 4'h0, 1'b0, 2);
    bus(8'hE8, 1, 1'b1, 4'h0, 1'b0, 2);
    for (int i = 0; i < 30; i++) rand_read();

    // 4MB mode; JP2 toggles after reset must not matter
    do_reset(1'b0);
    JP2 = 1'b1;
    bus(8'hE8, 1, 1'b1, 4'h0, 1'b0, 3);
    bus(8'hE8, 0, 1'b1, 4'h0, 1'b0, 2);
    for (int i = 8; i < 12; i++) bus(8'hE8, i, 1'b1, 4'h0, 1'b0, 2);
    bus(8'hE8, 'h30, 1'b1, 4'h0, 1'b0, 2);
    for (int i = 0; i < 20; i++) rand_read();

    // Ignored writes, invisible board, single commit per cycle, then configure
    for (int i = 0; i < 10; i++) rand_write(1'b0);
    bus(8'hE8, 'h24, 1'b0, 4'hA, 1'b1, 3);
    bus(8'hE8, 0, 1'b1, 4'h0, 1'b1, 3);
    bus(8'h00, 'h24, 1'b0, 4'hA, 1'b0, 3);
    push_exp(1'b0, 4'h0, 1'b1);
    @(posedge CLK); #2;
    A = {8'hE8, 9'h0, 6'h25}; RW_n = 1'b0; D_IN = 4'h6; CFGIN_n = 1'b0;
    UDS_n = 1'b0; AS_n = 1'b0;
    repeat (2) @(posedge CLK);
    #2 A = {8'hE8, 9'h0, 6'h24};
    repeat (2) @(posedge CLK);
    #2 AS_n = 1'b1; UDS_n = 1'b1;
    bus(8'hE8, 'h25, 1'b0, 4'h0, 1'b0, 2);
    bus(8'hE8, 'h24, 1'b0, 4'h2, 1'b0, 2);
    bus(8'hE8, 0, 1'b1, 4'h0, 1'b0, 2);
    bus(8'hE8, 'h26, 1'b0, 4'h0, 1'b0, 2);
    bus(8'hE8, 'h24, 1'b0, 4'hE, 1'b0, 2);
    for (int i = 0; i < 5; i++) rand_read();

    // RESET in the middle of a bus cycle while configured
    m_state = 0; m_base = 3'b000; m_8m = 1'b0;
    push_exp(1'b0, 4'h0, 1'b0);
    @(posedge CLK); #2;
    A = {8'hE8, 9'h0, 6'h00}; RW_n = 1'b1; UDS_n = 1'b0; CFGIN_n = 1'b0; AS_n = 1'b0;
    @(posedge CLK); #2;
    RESET = 1'b1; JP2 = 1'b0;
    @(posedge CLK); #2;
    RESET = 1'b0;
    repeat (3) @(posedge CLK);
    #2 AS_n = 1'b1; UDS_n = 1'b1;
    bus(8'hE8, 1, 1'b1, 4'h0, 1'b0, 2);

    // Shut-up path
    do_reset(1'($urandom));
    bus(8'hE8, 'h26, 1'b0, 4'($urandom), 1'b0, 2);
    bus(8'hE8, 'h24, 1'b0, 4'hE, 1'b0, 2);
    bus(8'hE8, 0, 1'b1, 4'h0, 1'b0, 2);

    // RESET on the same edge as a base-address commit
    do_reset(1'b0);
    m_state = 0; m_base = 3'b000; m_8m = 1'b1;
    push_exp(1'b0, 4'h0, 1'b0);
    @(posedge CLK); #2;
    A = {8'hE8, 9'h0, 6'h24}; RW_n = 1'b0; D_IN = 4'hC; CFGIN_n = 1'b0;
    UDS_n = 1'b0; AS_n = 1'b0; RESET = 1'b1; JP2 = 1'b1;
    @(posedge CLK); #2;
    RESET = 1'b0;
    repeat (3) @(posedge CLK);
    #2 AS_n = 1'b1; UDS_n = 1'b1;
    bus(8'hE8, 1, 1'b1, 4'h0, 1'b0, 2);
    bus(8'hE8, 'h24, 1'b0, 4'($urandom), 1'b0, 2);

    // Mixed random traffic across several resets
    for (int r = 0; r < 3; r++) begin
      do_reset(1'($urandom));
      for (int i = 0; i < 15; i++) begin
        if ($urandom_range(0, 1) == 0) rand_read();
        else rand_write(1'b1);
      end
    end

    repeat (3) @(posedge CLK);
    chk("sb_drained", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
